// File: rtl/gpio_serial_loader.sv
// Serial loader for the GPIO pad-configuration chain: reads one config word per
// GPIO, shifts all words out MSB first (farthest block first), then strobes load.
module gpio_serial_loader #(
   parameter int NUM_IO        = 19,
   parameter int PAD_CTRL_BITS = 13,
   parameter int CLK_DIV       = 4
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      cfg_rd_en,
   output logic [$clog2(NUM_IO)-1:0] cfg_rd_addr,
   input  logic [PAD_CTRL_BITS-1:0]  cfg_rd_data,
   output logic                      serial_clock,
   output logic                      serial_data,
   output logic                      serial_load,
   output logic                      serial_resetn
);

   localparam int AW = $clog2(NUM_IO);
   localparam int BW = $clog2(PAD_CTRL_BITS);
   localparam logic [7:0]    DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [AW-1:0] LAST_IO  = AW'(NUM_IO - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(PAD_CTRL_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SHIFT_LO,
      SHIFT_HI,
      LOAD_SETUP,
      LOAD_HI,
      DONE
   } state_t;

   state_t                   state;
   logic [AW-1:0]            word_idx;
   logic [BW-1:0]            bit_cnt;
   logic [7:0]               div_cnt;
   logic [PAD_CTRL_BITS-1:0] shift_word;
   logic                     div_end;

   assign div_end = (div_cnt == 8'd0);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         word_idx      <= '0;
         bit_cnt       <= '0;
         div_cnt       <= '0;
         shift_word    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         cfg_rd_en     <= 1'b0;
         cfg_rd_addr   <= '0;
         serial_clock  <= 1'b0;
         serial_data   <= 1'b0;
         serial_load   <= 1'b0;
         serial_resetn <= 1'b0;
      end else begin
         serial_resetn <= 1'b1;
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state       <= FETCH;
                  busy        <= 1'b1;
                  word_idx    <= LAST_IO;
                  cfg_rd_en   <= 1'b1;
                  cfg_rd_addr <= LAST_IO;
               end
            end
            FETCH: begin
               cfg_rd_en <= 1'b0;
               state     <= CAPTURE;
            end
            CAPTURE: begin
               shift_word  <= cfg_rd_data;
               bit_cnt     <= LAST_BIT;
               serial_data <= cfg_rd_data[PAD_CTRL_BITS-1];
               div_cnt     <= DIV_LOAD;
               state       <= SHIFT_LO;
            end
            SHIFT_LO: begin
               if (div_end) begin
                  serial_clock <= 1'b1;
                  div_cnt      <= DIV_LOAD;
                  state        <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  // data only moves on the edge where the clock falls
                  serial_clock <= 1'b0;
                  div_cnt      <= DIV_LOAD;
                  if (bit_cnt != '0) begin
                     bit_cnt     <= bit_cnt - BW'(1);
                     serial_data <= shift_word[bit_cnt - BW'(1)];
                     state       <= SHIFT_LO;
                  end else if (word_idx != '0) begin
                     word_idx    <= word_idx - AW'(1);
                     cfg_rd_en   <= 1'b1;
                     cfg_rd_addr <= word_idx - AW'(1);
                     state       <= FETCH;
                  end else begin
                     serial_data <= 1'b0;
                     state       <= LOAD_SETUP;
                  end
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            LOAD_SETUP: begin
               if (div_end) begin
                  serial_load <= 1'b1;
                  div_cnt     <= DIV_LOAD;
                  state       <= LOAD_HI;
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            LOAD_HI: begin
               if (div_end) begin
                  serial_load <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: CLK_DIV=1 instance checked cycle-by-cycle from a
// vector table plus a two-block chain model; CLK_DIV=4 instance checked for phase timing.
module tb_gpio_serial_loader;

   localparam logic [25:0] EXP_STREAM = {13'h0403, 13'h1803};
   localparam int NV = 16;

   typedef struct {
      int         k;    // cycles after the start edge
      logic [6:0] exp;  // {busy, done, cfg_rd_en, cfg_rd_addr, serial_clock, serial_data, serial_load}
   } vec_t;

   vec_t tbl[NV];
   int n_checks = 0;
   int n_fail   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        busy_a, done_a, rden_a, sc_a, sd_a, ld_a, rstn_a;
   logic        busy_b, done_b, rden_b, sc_b, sd_b, ld_b, rstn_b;
   logic [0:0]  addr_a, addr_b;
   logic [12:0] rdata_a = '0, rdata_b = '0;
   logic [6:0]  outs_a;

   assign outs_a = {busy_a, done_a, rden_a, addr_a, sc_a, sd_a, ld_a};

   gpio_serial_loader #(.NUM_IO(2), .PAD_CTRL_BITS(13), .CLK_DIV(1)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .cfg_rd_en(rden_a), .cfg_rd_addr(addr_a), .cfg_rd_data(rdata_a),
      .serial_clock(sc_a), .serial_data(sd_a), .serial_load(ld_a), .serial_resetn(rstn_a)
   );

   gpio_serial_loader #(.NUM_IO(2), .PAD_CTRL_BITS(13), .CLK_DIV(4)) u_dut4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .cfg_rd_en(rden_b), .cfg_rd_addr(addr_b), .cfg_rd_data(rdata_b),
      .serial_clock(sc_b), .serial_data(sd_b), .serial_load(ld_b), .serial_resetn(rstn_b)
   );

   // config register file: 1-cycle read latency
   always @(posedge clk) begin
      if (rden_a) rdata_a <= (addr_a == 1'b1) ? 13'h0403 : 13'h1803;
      if (rden_b) rdata_b <= (addr_b == 1'b1) ? 13'h0403 : 13'h1803;
   end

   // monitor A: edge counting, bit stream, two-block chain model, strobes
   int          edges_a = 0, ldp_a = 0, ldc_a = 0, rdc_a = 0, stab_a = 0, donec_a = 0;
   logic [25:0] stream_a = '0;
   logic [3:0]  rdlog_a = '0;
   logic [12:0] ch0 = '0, ch1 = '0, lat0 = '0, lat1 = '0;
   logic        sc_prev_a = 1'b0, sd_prev_a = 1'b0, ld_prev_a = 1'b0;

   always @(negedge clk) begin
      if (!rstn_a) begin
         ch0 <= '0; ch1 <= '0; lat0 <= '0; lat1 <= '0;
      end else begin
         if (sc_a && !sc_prev_a) begin
            ch0 <= {ch0[11:0], sd_a};
            ch1 <= {ch1[11:0], ch0[12]};
         end
         if (ld_a && !ld_prev_a) begin
            lat0 <= ch0;
            lat1 <= ch1;
         end
      end
      if (sc_a && !sc_prev_a) begin
         edges_a  <= edges_a + 1;
         stream_a <= {stream_a[24:0], sd_a};
      end
      if (ld_a && !ld_prev_a) ldp_a <= ldp_a + 1;
      if (sc_a && (sd_a !== sd_prev_a)) stab_a <= stab_a + 1;
      if (ld_a) ldc_a <= ldc_a + 1;
      if (rden_a) begin
         rdc_a   <= rdc_a + 1;
         rdlog_a <= {rdlog_a[2:0], addr_a};
      end
      if (done_a) donec_a <= donec_a + 1;
      sc_prev_a <= sc_a;
      sd_prev_a <= sd_a;
      ld_prev_a <= ld_a;
   end

   // monitor B: serial_clock run lengths
   int          edges_b = 0, ldc_b = 0, stab_b = 0, run_b = 0, hi_runs = 0, hi_bad = 0, lo4_runs = 0;
   logic [25:0] stream_b = '0;
   logic        sc_prev_b = 1'b0, sd_prev_b = 1'b0;

   always @(negedge clk) begin
      if (sc_b != sc_prev_b) begin
         if (sc_prev_b) begin
            hi_runs <= hi_runs + 1;
            if (run_b != 4) hi_bad <= hi_bad + 1;
         end else if (run_b == 4) begin
            lo4_runs <= lo4_runs + 1;
         end
         run_b <= 1;
      end else begin
         run_b <= run_b + 1;
      end
      if (sc_b && !sc_prev_b) begin
         edges_b  <= edges_b + 1;
         stream_b <= {stream_b[24:0], sd_b};
      end
      if (sc_b && (sd_b !== sd_prev_b)) stab_b <= stab_b + 1;
      if (ld_b) ldc_b <= ldc_b + 1;
      sc_prev_b <= sc_b;
      sd_prev_b <= sd_b;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_basic(input string tag);
      int e0, lp0, lc0, rc0, st0, dc0, ti;
      e0 = edges_a; lp0 = ldp_a; lc0 = ldc_a; rc0 = rdc_a; st0 = stab_a; dc0 = donec_a; ti = 0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (ti < NV && tbl[ti].k == k) begin
            chk($sformatf("%s vec k=%0d", tag, k), 32'(outs_a), 32'(tbl[ti].exp));
            ti++;
         end
      end
      @(posedge clk); #1;
      chk({tag, " rising edges"}, 32'(edges_a - e0), 32'd26);
      chk({tag, " bit stream"}, 32'(stream_a), 32'(EXP_STREAM));
      chk({tag, " load pulses"}, 32'(ldp_a - lp0), 32'd1);
      chk({tag, " load width"}, 32'(ldc_a - lc0), 32'd1);
      chk({tag, " read count"}, 32'(rdc_a - rc0), 32'd2);
      chk({tag, " read order"}, 32'(rdlog_a[1:0]), 32'd2);
      chk({tag, " data stable"}, 32'(stab_a - st0), 32'd0);
      chk({tag, " done pulses"}, 32'(donec_a - dc0), 32'd1);
      chk({tag, " block0 word"}, 32'(lat0), 32'h1803);
      chk({tag, " block1 word"}, 32'(lat1), 32'h0403);
   endtask

   initial begin
      int e0, d0, r0, lp0, st0, hr0, hb0, l40, lc0, done_k;
      tbl[0]  = '{1,  7'b1011000};
      tbl[1]  = '{2,  7'b1001000};
      tbl[2]  = '{3,  7'b1001000};
      tbl[3]  = '{4,  7'b1001100};
      tbl[4]  = '{7,  7'b1001010};
      tbl[5]  = '{8,  7'b1001110};
      tbl[6]  = '{28, 7'b1001110};
      tbl[7]  = '{29, 7'b1010010};
      tbl[8]  = '{31, 7'b1000010};
      tbl[9]  = '{34, 7'b1000110};
      tbl[10] = '{35, 7'b1000000};
      tbl[11] = '{56, 7'b1000110};
      tbl[12] = '{57, 7'b1000000};
      tbl[13] = '{58, 7'b1000001};
      tbl[14] = '{59, 7'b1100000};
      tbl[15] = '{60, 7'b0000000};

      // reset held for 3 cycles, then idle
      e0 = edges_a;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("reset outputs %0d", i), 32'({outs_a, rstn_a}), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk("resetn after release", 32'(rstn_a), 32'd1);
      chk("busy idle", 32'(busy_a), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("idle no clock", 32'(edges_a - e0), 32'd0);
      chk("idle outputs", 32'({outs_a, rstn_a}), 32'd1);

      run_basic("basic");

      // start while busy and in the DONE cycle
      e0 = edges_a; d0 = donec_a; r0 = rdc_a;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (k == 59) chk("done cycle", 32'(done_a), 32'd1);
         if (k == 60) chk("busy after done", 32'({busy_a, done_a}), 32'd0);
         start_a = (k == 10 || k == 59);
      end
      chk("busy start done count", 32'(donec_a - d0), 32'd1);
      chk("busy start reads", 32'(rdc_a - r0), 32'd2);
      chk("busy start edges", 32'(edges_a - e0), 32'd26);
      chk("busy start idle", 32'(busy_a), 32'd0);

      // reset after the 7th rising edge
      e0 = edges_a; lp0 = ldp_a;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int i = 0; i < 100 && (edges_a - e0) < 7; i++) begin
         @(posedge clk); #1;
      end
      chk("reach edge 7", 32'(edges_a - e0), 32'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset outputs", 32'({sc_a, ld_a, rstn_a, busy_a}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midreset resetn back", 32'(rstn_a), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("midreset no load", 32'(ldp_a - lp0), 32'd0);
      chk("midreset edges frozen", 32'(edges_a - e0), 32'd7);

      run_basic("rerun");

      // CLK_DIV=4 timing
      e0 = edges_b; st0 = stab_b; hr0 = hi_runs; hb0 = hi_bad; l40 = lo4_runs; lc0 = ldc_b;
      done_k = -1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (done_b) begin
            done_k = k;
            break;
         end
      end
      chk("div4 done cycle", 32'(done_k), 32'd221);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("div4 edges", 32'(edges_b - e0), 32'd26);
      chk("div4 stream", 32'(stream_b), 32'(EXP_STREAM));
      chk("div4 high phases", 32'(hi_runs - hr0), 32'd26);
      chk("div4 high not 4", 32'(hi_bad - hb0), 32'd0);
      chk("div4 low phases of 4", 32'(l40 == 0 ? lo4_runs : lo4_runs - l40), 32'd24);
      chk("div4 load width", 32'(ldc_b - lc0), 32'd4);
      chk("div4 data stable", 32'(stab_b - st0), 32'd0);
      chk("div4 idle", 32'(busy_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
